// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the request port, the ALU drive/return signals and the
// response port of the ALU issue unit.
//
//   slave  modport : the issue unit itself.
//   master modport : its environment (decode stage driving requests, the ALU
//                    returning aluOut/zero/carry, and the response consumer).
//
// Signals
//   req_valid/req_ready       request handshake
//   funct3, funct7b5, is_imm, is_lui, rs1_val, rs2_val, imm_val  request fields
//   alu_ctrl, alu_op1, alu_op2                 drive to the ALU
//   alu_out, alu_zero, alu_carry               result from the ALU
//   rsp_valid/rsp_ready                        response handshake
//   rsp_data, rsp_zero, rsp_carry, rsp_illegal response fields
interface alu_issue_if #(
   parameter int Width = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       funct3;
   logic             funct7b5;
   logic             is_imm;
   logic             is_lui;
   logic [Width-1:0] rs1_val;
   logic [Width-1:0] rs2_val;
   logic [Width-1:0] imm_val;

   logic [3:0]       alu_ctrl;
   logic [Width-1:0] alu_op1;
   logic [Width-1:0] alu_op2;
   logic [Width-1:0] alu_out;
   logic             alu_zero;
   logic             alu_carry;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [Width-1:0] rsp_data;
   logic             rsp_zero;
   logic             rsp_carry;
   logic             rsp_illegal;

   modport slave (
      input  req_valid, funct3, funct7b5, is_imm, is_lui,
             rs1_val, rs2_val, imm_val,
             alu_out, alu_zero, alu_carry, rsp_ready,
      output req_ready, alu_ctrl, alu_op1, alu_op2,
             rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_illegal
   );

   modport master (
      output req_valid, funct3, funct7b5, is_imm, is_lui,
             rs1_val, rs2_val, imm_val,
             alu_out, alu_zero, alu_carry, rsp_ready,
      input  req_ready, alu_ctrl, alu_op1, alu_op2,
             rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_illegal
   );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: accepts RISC-V integer-op requests, decodes them to the
// 4-bit ALU control code, drives the ALU from registered operands for one
// cycle, captures result and flags, and presents them on a response port.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        alu_issue_if.slave (request, ALU drive/return, response)
//   dbg_state  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. valid, once raised, holds its payload stable until that edge;
// ready may depend combinationally on the other side's ready (req_ready
// follows rsp_ready in RESP so a new request can be taken on the same edge
// the response is consumed).
module alu_issue_unit #(
   parameter int Width = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_issue_if.slave bus,
   output logic [1:0] dbg_state
);

   localparam logic [3:0] CTRL_ADD  = 4'd0;
   localparam logic [3:0] CTRL_SUB  = 4'd1;
   localparam logic [3:0] CTRL_AND  = 4'd2;
   localparam logic [3:0] CTRL_OR   = 4'd3;
   localparam logic [3:0] CTRL_XOR  = 4'd4;
   localparam logic [3:0] CTRL_SLL  = 4'd5;
   localparam logic [3:0] CTRL_SRL  = 4'd6;
   localparam logic [3:0] CTRL_SRA  = 4'd7;
   localparam logic [3:0] CTRL_SLT  = 4'd8;
   localparam logic [3:0] CTRL_SLTU = 4'd9;
   localparam logic [3:0] CTRL_PASS = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [3:0]       ctrl_q;
   logic [Width-1:0] op1_q;
   logic [Width-1:0] op2_q;
   logic [Width-1:0] rsp_data_q;
   logic             rsp_zero_q;
   logic             rsp_carry_q;
   logic             rsp_illegal_q;

   logic [3:0]       dec_ctrl;
   logic             dec_illegal;
   logic [Width-1:0] dec_op2;
   logic             accept;

   // Request decode, evaluated every cycle but only used on an accept.
   always_comb begin
      dec_ctrl    = CTRL_ADD;
      dec_illegal = 1'b0;
      dec_op2     = bus.is_imm ? bus.imm_val : bus.rs2_val;
      if (bus.is_lui) begin
         dec_ctrl = CTRL_PASS;
         dec_op2  = bus.imm_val;
      end else begin
         unique case (bus.funct3)
            3'b000:  dec_ctrl = (!bus.is_imm && bus.funct7b5) ? CTRL_SUB : CTRL_ADD;
            3'b001:  dec_ctrl = CTRL_SLL;
            3'b010:  dec_ctrl = CTRL_SLT;
            3'b011:  dec_ctrl = CTRL_SLTU;
            3'b100:  dec_ctrl = CTRL_XOR;
            3'b101:  dec_ctrl = bus.funct7b5 ? CTRL_SRA : CTRL_SRL;
            3'b110:  dec_ctrl = CTRL_OR;
            default: dec_ctrl = CTRL_AND;
         endcase
         // I-type only uses bit 30 to tell SRAI from SRLI; SLLI with it set
         // is the one I-type encoding that cannot exist.
         if (bus.is_imm) begin
            dec_illegal = bus.funct7b5 && (bus.funct3 == 3'b001);
         end else begin
            dec_illegal = bus.funct7b5 && (bus.funct3 != 3'b000) &&
                          (bus.funct3 != 3'b101);
         end
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               state_d = dec_illegal ? RESP : EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               bus.req_ready = 1'b1;
               if (bus.req_valid) begin
                  state_d = dec_illegal ? RESP : EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign accept = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q        <= '0;
         op1_q         <= '0;
         op2_q         <= '0;
         rsp_data_q    <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_carry_q   <= 1'b0;
         rsp_illegal_q <= 1'b0;
      end else if (accept) begin
         ctrl_q <= dec_ctrl;
         op1_q  <= bus.rs1_val;
         op2_q  <= dec_op2;
         // An illegal request skips EXEC, so its response is formed here.
         // A legal one leaves the response registers alone until EXEC ends.
         if (dec_illegal) begin
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_carry_q   <= 1'b0;
            rsp_illegal_q <= 1'b1;
         end
      end else if (state_q == EXEC) begin
         rsp_data_q    <= bus.alu_out;
         rsp_zero_q    <= bus.alu_zero;
         rsp_carry_q   <= bus.alu_carry;
         rsp_illegal_q <= 1'b0;
      end
   end

   // The ALU sees only registered values, so its inputs never toggle
   // outside the cycle in which a new request is latched.
   assign bus.alu_ctrl    = ctrl_q;
   assign bus.alu_op1     = op1_q;
   assign bus.alu_op2     = op2_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_zero    = rsp_zero_q;
   assign bus.rsp_carry   = rsp_carry_q;
   assign bus.rsp_illegal = rsp_illegal_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: self-checking bench for alu_issue_unit. Provides a
// behavioural ALU behind the unit, a decode-sweep vector table, directed
// multi-cycle sequences (latency, back-pressure, reset) and a randomized
// phase checked by a request-level reference model through an expected queue.
module tb_alu_issue_unit;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   alu_issue_if #(.Width(W)) bus ();

   alu_issue_unit #(.Width(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int           n_checks = 0;
   int           n_errors = 0;
   logic [W+2:0] exp_q[$];   // {illegal, carry, zero, data}
   logic         mon_en = 1'b0;
   logic         drv_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // ALU operation selected by control code; returns {carry, data}.
   function automatic logic [W:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      int         sh;
      logic [W-1:0] d;
      logic       cy;
      sh = int'(b) % W;
      cy = 1'b0;
      d  = '0;
      case (c)
         4'd0:  {cy, d} = {1'b0, a} + {1'b0, b};
         4'd1:  begin d = a - b; cy = (a < b); end
         4'd2:  d = a & b;
         4'd3:  d = a | b;
         4'd4:  d = a ^ b;
         4'd5:  d = a << sh;
         4'd6:  d = a >> sh;
         4'd7:  d = W'($signed(a) >>> sh);
         4'd8:  d = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         4'd9:  d = (a < b) ? W'(1) : W'(0);
         4'd10: d = b;
         default: d = '0;
      endcase
      return {cy, d};
   endfunction

   // Instruction-level decode: {illegal, ctrl}.
   function automatic logic [4:0] model_dec(input logic is_imm, input logic f7,
                                            input logic [2:0] f3, input logic lui);
      logic [3:0] c;
      logic       ill;
      if (lui) return {1'b0, 4'd10};
      case (f3)
         3'd0: c = (f7 && !is_imm) ? 4'd1 : 4'd0;
         3'd1: c = 4'd5;
         3'd2: c = 4'd8;
         3'd3: c = 4'd9;
         3'd4: c = 4'd4;
         3'd5: c = f7 ? 4'd7 : 4'd6;
         3'd6: c = 4'd3;
         default: c = 4'd2;
      endcase
      if (is_imm) ill = f7 && (f3 == 3'd1);
      else        ill = f7 && !(f3 == 3'd0 || f3 == 3'd5);
      return {ill, c};
   endfunction

   function automatic logic [W+2:0] rsp_of(input logic ill, input logic [3:0] c,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] r;
      if (ill) return {1'b1, 2'b00, W'(0)};
      r = alu_fn(c, a, b);
      return {1'b0, r[W], (r[W-1:0] == '0), r[W-1:0]};
   endfunction

   // ---------------- behavioural ALU behind the unit ----------------
   logic [W:0] alu_res;
   always_comb begin
      alu_res       = alu_fn(bus.alu_ctrl, bus.alu_op1, bus.alu_op2);
      bus.alu_out   = alu_res[W-1:0];
      bus.alu_carry = alu_res[W];
      bus.alu_zero  = (alu_res[W-1:0] == '0);
   end

   function automatic logic [W+2:0] rsp_now();
      return {bus.rsp_illegal, bus.rsp_carry, bus.rsp_zero, bus.rsp_data};
   endfunction

   // ---------------- monitor for the randomized phase ----------------
   // Sampled on the falling edge: what is seen here is what the next rising
   // edge will act on.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.req_valid && bus.req_ready) begin
            logic [4:0] dc;
            dc = model_dec(bus.is_imm, bus.funct7b5, bus.funct3, bus.is_lui);
            exp_q.push_back(rsp_of(dc[4], dc[3:0], bus.rs1_val,
                                   (bus.is_imm || bus.is_lui) ? bus.imm_val : bus.rs2_val));
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rand_unexpected_rsp", 32'(rsp_now()), 32'h7ff_ffff);
            end else begin
               chk("rand_rsp", 32'(rsp_now()), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input logic is_imm, input logic f7, input logic [2:0] f3,
                          input logic lui, input logic [W-1:0] rs1,
                          input logic [W-1:0] rs2, input logic [W-1:0] imm);
      bus.is_imm   = is_imm;
      bus.funct7b5 = f7;
      bus.funct3   = f3;
      bus.is_lui   = lui;
      bus.rs1_val  = rs1;
      bus.rs2_val  = rs2;
      bus.imm_val  = imm;
   endtask

   task automatic scramble_req();
      set_req(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), W'($urandom),
              W'($urandom), W'($urandom));
   endtask

   // Called #1 after a rising edge with the unit idle. Issues one request,
   // checks the EXEC-cycle ALU drive, latency and the response, then drains it.
   task automatic send_and_check(input logic is_imm, input logic f7, input logic [2:0] f3,
                                 input logic lui, input logic [W-1:0] rs1,
                                 input logic [W-1:0] rs2, input logic [W-1:0] imm,
                                 input logic [3:0] ec, input logic eill, input string nm);
      logic [W-1:0] eop2;
      eop2 = (is_imm || lui) ? imm : rs2;
      set_req(is_imm, f7, f3, lui, rs1, rs2, imm);
      bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b0;
      exp_q.push_back(rsp_of(eill, ec, rs1, eop2));
      #1;
      chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      scramble_req();
      if (!eill) begin
         chk({nm, "_exec_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
         chk({nm, "_alu_ctrl"}, 32'(bus.alu_ctrl), 32'(ec));
         chk({nm, "_alu_ops"}, 32'({bus.alu_op1, bus.alu_op2}), 32'({rs1, eop2}));
         @(posedge clk); #1;
      end
      chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, "_rsp"}, 32'(rsp_now()), 32'(exp_q.pop_front()));
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk({nm, "_drained"}, 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
   endtask

   // ---------------- decode sweep table ----------------
   typedef struct {
      logic       is_imm;
      logic       f7;
      logic [2:0] f3;
      logic [3:0] exp_ctrl;
      logic       exp_ill;
   } vec_t;

   vec_t       vecs[32];
   logic [3:0] base_ctrl[8];

   // ---------------- main sequence ----------------
   initial begin
      logic [W+2:0] held;
      logic [W+2:0] e;

      base_ctrl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
      for (int k = 0; k < 32; k++) begin
         vecs[k].is_imm   = k[4];
         vecs[k].f7       = k[3];
         vecs[k].f3       = k[2:0];
         vecs[k].exp_ctrl = base_ctrl[k[2:0]];
         vecs[k].exp_ill  = 1'b0;
         if (k[3]) begin
            if (k[2:0] == 3'd5) vecs[k].exp_ctrl = 4'd7;
            if (!k[4]) begin
               if (k[2:0] == 3'd0) vecs[k].exp_ctrl = 4'd1;
               else if (k[2:0] != 3'd5) vecs[k].exp_ill = 1'b1;
            end else if (k[2:0] == 3'd1) begin
               vecs[k].exp_ill = 1'b1;
            end
         end
      end

      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      set_req(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, '0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp", 32'({bus.rsp_valid, rsp_now()}), 32'd0);
      chk("reset_alu", 32'({bus.alu_ctrl, bus.alu_op1, bus.alu_op2}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_ready", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);

      // Directed operations
      send_and_check(1'b0, 1'b0, 3'd0, 1'b0, 8'd10, 8'd4, 8'd0, 4'd0, 1'b0, "add_10_4");
      send_and_check(1'b0, 1'b1, 3'd0, 1'b0, 8'd10, 8'd10, 8'd0, 4'd1, 1'b0, "sub_zero");
      send_and_check(1'b0, 1'b0, 3'd0, 1'b0, 8'd200, 8'd100, 8'd0, 4'd0, 1'b0, "add_carry");
      send_and_check(1'b1, 1'b1, 3'd5, 1'b0, 8'h80, 8'd55, 8'd2, 4'd7, 1'b0, "srai");
      send_and_check(1'b1, 1'b1, 3'd0, 1'b0, 8'd3, 8'd99, 8'd4, 4'd0, 1'b0, "addi_f7");
      send_and_check(1'b0, 1'b1, 3'd1, 1'b0, 8'd7, 8'd9, 8'd0, 4'd5, 1'b1, "r_illegal");
      send_and_check(1'b0, 1'b1, 3'd1, 1'b1, 8'd7, 8'd9, 8'hA5, 4'd10, 1'b0, "lui");

      // Decode sweep
      for (int k = 0; k < 32; k++) begin
         send_and_check(vecs[k].is_imm, vecs[k].f7, vecs[k].f3, 1'b0, W'($urandom),
                        W'($urandom), W'($urandom_range(0, 15)), vecs[k].exp_ctrl,
                        vecs[k].exp_ill, $sformatf("sweep%0d", k));
      end

      // Back-pressure with a request pending, then back-to-back accept
      set_req(1'b0, 1'b0, 3'd0, 1'b0, 8'd7, 8'd9, 8'd0);
      bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 3'd0, 1'b0, 8'd50, 8'd20, 8'd0);
      @(posedge clk); #1;
      held = rsp_now();
      chk("bp_first_rsp", 32'(held), 32'(rsp_of(1'b0, 4'd0, 8'd7, 8'd9)));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold", 32'({bus.rsp_valid, bus.req_ready, rsp_now()}),
             32'({2'b10, held}));
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_ready_follows", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      chk("b2b_exec", 32'({bus.rsp_valid, bus.alu_ctrl, bus.alu_op1, bus.alu_op2}),
          32'({1'b0, 4'd1, 8'd50, 8'd20}));
      @(posedge clk); #1;
      chk("b2b_rsp", 32'({bus.rsp_valid, rsp_now()}),
          32'({1'b1, rsp_of(1'b0, 4'd1, 8'd50, 8'd20)}));
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;

      // Reset mid-EXEC
      set_req(1'b0, 1'b0, 3'd4, 1'b0, 8'd33, 8'd12, 8'd0);
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("pre_rst_exec", 32'(bus.alu_ctrl), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_exec_rsp", 32'({bus.rsp_valid, rsp_now()}), 32'd0);
      chk("rst_exec_alu", 32'({bus.alu_ctrl, bus.alu_op1, bus.alu_op2}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_exec_idle", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);

      // Reset mid-RESP
      set_req(1'b0, 1'b0, 3'd6, 1'b0, 8'h31, 8'h42, 8'd0);
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_resp", 32'({bus.rsp_valid, rsp_now()}),
          32'({1'b1, rsp_of(1'b0, 4'd3, 8'h31, 8'h42)}));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_resp_rsp", 32'({bus.rsp_valid, rsp_now()}), 32'd0);
      chk("rst_resp_alu", 32'({bus.alu_ctrl, bus.alu_op1, bus.alu_op2}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_and_check(1'b1, 1'b0, 3'd2, 1'b0, 8'hF0, 8'd0, 8'd5, 4'd8, 1'b0, "post_rst_slti");

      // Randomized traffic with random back-pressure
      exp_q.delete();
      mon_en = 1'b1;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               logic accepted;
               set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                       W'($urandom), W'($urandom), W'($urandom));
               bus.req_valid = 1'b1;
               accepted = 1'b0;
               for (int c = 0; c < 40 && !accepted; c++) begin
                  @(negedge clk);
                  accepted = bus.req_ready;
                  @(posedge clk); #1;
               end
               if (!accepted) chk("rand_accept_timeout", 32'd0, 32'd1);
               bus.req_valid = 1'b0;
               scramble_req();
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk); #1;
               end
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk); #1;
               bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
            bus.rsp_ready = 1'b1;
         end
      join
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
         @(posedge clk); #1;
      end
      chk("rand_drain", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
